// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserialises LSB-first even-parity frames into a one-entry valid/ready buffer with error stats
module serial_parity_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  err_count,
  output logic              overflow,
  input  logic              clear_err
);
  localparam int CW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_q, perr_d, valid_q, valid_d, ovf_q, ovf_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic done, perr, drop;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    if (rx_valid) begin
      if (rx_sof) begin
        shift_d = DATA_W'(rx_bit);
        cnt_d = CW'(1);
        state_d = (DATA_W == 1) ? PARITY : DATA;
      end else if (state_q == DATA) begin
        for (int i = 0; i < DATA_W; i++) if (cnt_q == CW'(i)) shift_d[i] = rx_bit;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(DATA_W - 1)) ? PARITY : DATA;
      end else if (state_q == PARITY) begin
        cnt_d = '0;
        state_d = IDLE;
      end
    end
  end
  assign done = rx_valid && !rx_sof && state_q == PARITY;
  assign perr = ^shift_q ^ rx_bit;
  // A completing frame may reuse the slot being read out in the same cycle
  assign drop = done && valid_q && !out_ready;
  always_comb begin
    data_d = data_q;
    perr_d = perr_q;
    valid_d = valid_q;
    if (done && !drop) begin
      data_d = shift_q;
      perr_d = perr;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    err_d = clear_err ? '0 : (done && perr && err_q != '1) ? err_q + CNT_W'(1) : err_q;
    ovf_d = clear_err ? 1'b0 : (ovf_q || drop);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      perr_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      perr_q <= perr_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_data = data_q;
  assign out_perr = perr_q;
  assign out_valid = valid_q;
  assign err_count = err_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: random and directed stimulus against a queue-based frame model
module tb_serial_parity_checker;
  localparam int DW = 8;
  localparam int CNTW = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0, rx_valid = 1'b0, rx_sof = 1'b0, rx_bit = 1'b0, out_ready = 1'b0, clear_err = 1'b0;
  logic [DW-1:0] out_data;
  logic out_perr, out_valid, overflow;
  logic [CNTW-1:0] err_count;
  int checks = 0, errors = 0;
  bit q[$];
  bit mv, mp, movf;
  int md, merr;

  serial_parity_checker #(.DATA_W(DW), .CNT_W(CNTW)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_bit(rx_bit),
    .out_data(out_data), .out_perr(out_perr), .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count), .overflow(overflow), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit v, input bit s, input bit b, input bit rdy, input bit clr);
    bit done, dropped, p;
    int d;
    rstn = rn; rx_valid = v; rx_sof = s; rx_bit = b; out_ready = rdy; clear_err = clr;
    @(posedge clk);
    #1;
    done = 0; dropped = 0; d = 0; p = 0;
    if (!rn) begin
      q.delete(); mv = 0; md = 0; mp = 0; merr = 0; movf = 0;
    end else begin
      if (v) begin
        if (s) begin
          q.delete();
          q.push_back(b);
        end else if (q.size() > 0) begin
          q.push_back(b);
          if (q.size() == DW + 1) begin
            done = 1;
            foreach (q[i]) begin
              if (i < DW) d += int'(q[i]) << i;
              p ^= q[i];
            end
            q.delete();
          end
        end
      end
      if (done) begin
        if (!mv || rdy) begin mv = 1; md = d; mp = p; end
        else dropped = 1;
      end else if (mv && rdy) mv = 0;
      if (clr) begin merr = 0; movf = 0; end
      else begin
        if (done && p && merr < (1 << CNTW) - 1) merr++;
        if (dropped) movf = 1;
      end
    end
    chk("out_valid", int'(out_valid), int'(mv));
    chk("out_data", int'(out_data), md);
    chk("out_perr", int'(out_perr), int'(mp));
    chk("err_count", int'(err_count), merr);
    chk("overflow", int'(overflow), int'(movf));
  endtask

  task automatic gap(input bit en, input bit rdy);
    if (en) repeat ($urandom_range(0, 2)) step(1, 0, 1'($urandom), 1'($urandom), rdy, 0);
  endtask

  task automatic send(input logic [DW-1:0] data, input bit par, input bit gaps, input bit rdy, input bit clr);
    step(1, 1, 1, data[0], rdy, 0);
    for (int i = 1; i < DW; i++) begin
      gap(gaps, rdy);
      step(1, 1, 0, data[i], rdy, 0);
    end
    gap(gaps, rdy);
    step(1, 1, 0, par, rdy, clr);
  endtask

  task automatic tests_1_to_4(input bit g);
    send(8'hA5, 0, g, 1, 0);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_data", int'(out_data), 'hA5);
    chk("t1_perr", int'(out_perr), 0);
    step(1, 1, 0, 1, 1, 1);
    send(8'hA5, 1, g, 1, 0);
    chk("t2_perr", int'(out_perr), 1);
    chk("t2_err", int'(err_count), 1);
    send(8'h01, 1, g, 1, 0);
    chk("t2b_perr", int'(out_perr), 0);
    chk("t2b_err", int'(err_count), 1);
    step(1, 0, 0, 0, 1, 0);
    send(8'h11, 0, g, 0, 0);
    send(8'h22, 0, g, 0, 0);
    chk("t3_data", int'(out_data), 'h11);
    chk("t3_ovf", int'(overflow), 1);
    step(1, 0, 0, 0, 1, 0);
    chk("t3_valid", int'(out_valid), 0);
    step(1, 1, 1, 1, 1, 0);
    gap(g, 1);
    step(1, 1, 0, 1, 1, 0);
    gap(g, 1);
    step(1, 1, 0, 0, 1, 0);
    send(8'h3C, 0, g, 1, 1);
    chk("t4_data", int'(out_data), 'h3C);
    chk("t4_perr", int'(out_perr), 0);
    chk("t4_err", int'(err_count), 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0);
    chk("rst_valid", int'(out_valid), 0);
    tests_1_to_4(0);
    step(1, 0, 0, 0, 1, 1);
    for (int k = 0; k < 256; k++) send(8'h00, 1, 0, 1, 0);
    chk("t5_sat", int'(err_count), 255);
    send(8'h00, 1, 0, 1, 1);
    chk("t5_clr_err", int'(err_count), 0);
    chk("t5_clr_ovf", int'(overflow), 0);
    step(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_data", int'(out_data), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 1, 0);
    chk("t6_idle", int'(out_valid), 0);
    send(8'hF0, 0, 0, 1, 0);
    chk("t6_data2", int'(out_data), 'hF0);
    chk("t6_perr", int'(out_perr), 0);
    tests_1_to_4(1);
    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
           1'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
